// File: rtl/mem_stage.sv
// Load/store access stage: decodes memory ops from execute, runs a req/ack
// transaction with data memory, and returns left-aligned load data.

module mem_stage_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] sd,
    output logic [7:0]  wbyte,
    output logic        strb
);
    localparam logic [1:0] LN = 2'(LANE);

    // Sub-word stores replicate the low bytes across lanes; strobes pick the target.
    always_comb begin
        wbyte = sd[8*LANE +: 8];
        strb  = 1'b1;
        case (size)
            2'b00: begin
                wbyte = sd[7:0];
                strb  = (off == LN);
            end
            2'b01: begin
                wbyte = sd[8*(LANE%2) +: 8];
                strb  = (off[1] == LN[1]);
            end
            default: ;
        endcase
    end
endmodule

module mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [31:0]     store_data,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [31:0]     memData,
    output logic            data_valid,
    output logic            misaligned,
    output logic            bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [XLEN-3:0] waddr_q, waddr_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     memdata_q, memdata_d;
    logic            mis_q, mis_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load, is_store, is_mem, aligned;
    logic            start, reject;
    logic [3:0][7:0] lane_wdata;
    logic [3:0]      lane_strb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_fmt;
    logic            unused_funct;

    assign opcode       = operation[6:0];
    assign funct3       = operation[9:7];
    assign unused_funct = ^operation[11:10];
    assign is_load      = (opcode == OP_LOAD);
    assign is_store     = (opcode == OP_STORE);
    assign is_mem       = is_load | is_store;

    // Unknown size encodings fall into the misaligned path so they never reach the bus.
    always_comb begin
        aligned = 1'b0;
        case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr[0];
            3'b010:         aligned = (addr[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign start  = (state_q == IDLE) & valid_in & is_mem & aligned;
    assign reject = (state_q == IDLE) & valid_in & is_mem & ~aligned;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mem_stage_lane #(.LANE(i)) u_lane (
            .size  (funct3[1:0]),
            .off   (addr[1:0]),
            .sd    (store_data),
            .wbyte (lane_wdata[i]),
            .strb  (lane_strb[i])
        );
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_fmt = {ld_byte, 24'b0};
            2'b01:   ld_fmt = {ld_half, 16'b0};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        memdata_d = memdata_q;
        mis_d     = reject;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = BUSY;
                    waddr_d  = addr[XLEN-1:2];
                    off_d    = addr[1:0];
                    funct3_d = funct3;
                    we_d     = is_store;
                    wdata_d  = is_store ? lane_wdata : 32'b0;
                    wstrb_d  = is_store ? lane_strb : 4'b0;
                    cnt_d    = 8'd0;
                    err_d    = 1'b0;
                end
            end
            BUSY: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (mem_ack) begin
                    state_d = RESP;
                    if (!we_q) memdata_d = ld_fmt;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            off_q     <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            memdata_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            memdata_q <= memdata_d;
            mis_q     <= mis_d;
        end
    end

    // Stall drops in RESP so upstream advances while memData is already valid.
    assign stall      = start | (state_q == BUSY);
    assign mem_req    = (state_q == BUSY);
    assign mem_we     = we_q;
    assign mem_addr   = {waddr_q, 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign memData    = memdata_q;
    assign data_valid = (state_q == RESP) & ~err_q & ~we_q;
    assign bus_err    = (state_q == RESP) & err_q;
    assign misaligned = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops checked against
// an arithmetic model of the load/store rules.

module tb_mem_stage;
    localparam int TO  = 4;
    localparam int WIN = TO + 5;

    logic        clk, reset, valid_in, stall, mem_req, mem_we, mem_ack;
    logic        data_valid, misaligned, bus_err;
    logic [11:0] operation;
    logic [31:0] addr, store_data, mem_addr, mem_wdata, mem_rdata, memData;
    logic [3:0]  mem_wstrb;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_md;

    typedef struct packed {
        logic [15:0] stall_m;
        int          req_n;
        int          dv_n;
        int          dv_cyc;
        int          be_n;
        int          be_cyc;
        int          mis_n;
        int          mis_cyc;
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        unstable;
        logic [31:0] md_dv;
        logic [31:0] md_end;
    } obs_t;

    mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .operation(operation),
        .addr(addr), .store_data(store_data), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .memData(memData), .data_valid(data_valid), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [11:0] mk(input logic [2:0] f3, input logic st);
        return {2'b00, f3, st ? 7'b0100011 : 7'b0000011};
    endfunction

    function automatic int op_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ld_exp(input int sz, input int off, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        if (sz == 4) return rd;
        if (sz == 2) return (sh & 32'hFFFF) << 16;
        return (sh & 32'hFF) << 24;
    endfunction

    function automatic logic [31:0] st_wd(input int sz, input logic [31:0] sd);
        if (sz == 1) return {4{sd[7:0]}};
        if (sz == 2) return {2{sd[15:0]}};
        return sd;
    endfunction

    function automatic logic [3:0] st_strb(input int sz, input int off);
        int m;
        m = ((1 << sz) - 1) << off;
        return 4'(m);
    endfunction

    // Drives one op for a fixed window; ack arrives on BUSY cycle d (d<0: never).
    task automatic do_op(input logic [11:0] op, input logic [31:0] ad, input logic [31:0] sd,
                         input int d, input logic [31:0] rd, output obs_t o);
        int  bc;
        bit  seen;
        o = '0;
        o.dv_cyc = -1; o.be_cyc = -1; o.mis_cyc = -1;
        bc = 0; seen = 0;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            valid_in = (c == 0); operation = op; addr = ad; store_data = sd;
            mem_ack   = mem_req && (bc == d);
            mem_rdata = mem_ack ? rd : $urandom;
            #1;
            if (stall) o.stall_m[c] = 1'b1;
            if (mem_req) begin
                if (!seen) begin
                    o.a = mem_addr; o.we = mem_we; o.wd = mem_wdata; o.st = mem_wstrb;
                    seen = 1;
                end else if (mem_addr !== o.a || mem_we !== o.we || mem_wdata !== o.wd || mem_wstrb !== o.st)
                    o.unstable = 1'b1;
                o.req_n = o.req_n + 1;
                bc++;
            end
            if (data_valid) begin o.dv_n = o.dv_n + 1; o.dv_cyc = c; o.md_dv = memData; end
            if (bus_err)    begin o.be_n = o.be_n + 1; o.be_cyc = c; end
            if (misaligned) begin o.mis_n = o.mis_n + 1; o.mis_cyc = c; end
        end
        o.md_end = memData;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if ({stall, mem_req, mem_we, data_valid, bus_err, misaligned} !== 6'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 000000", {stall, mem_req, mem_we, data_valid, bus_err, misaligned}); end
        n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin n_err++; $display("FAIL reset_bus: addr %h wdata %h wstrb %b want all 0", mem_addr, mem_wdata, mem_wstrb); end
        n_vec++; if (memData !== 32'h0) begin n_err++; $display("FAIL reset_memData: got %h want 0", memData); end
        exp_md = 32'h0;
    endtask

    task automatic test_lw();
        obs_t o;
        do_op(mk(3'b010, 1'b0), 32'h100, 32'h0, 0, 32'hDEADBEEF, o);
        n_vec++; if (o.a !== 32'h100) begin n_err++; $display("FAIL lw_addr: got %h want 00000100", o.a); end
        n_vec++; if (o.we !== 1'b0 || o.st !== 4'b0) begin n_err++; $display("FAIL lw_we_strb: got we %b strb %b want 0 0000", o.we, o.st); end
        n_vec++; if (o.req_n !== 1) begin n_err++; $display("FAIL lw_req_cycles: got %0d want 1", o.req_n); end
        n_vec++; if (o.dv_n !== 1 || o.dv_cyc !== 2) begin n_err++; $display("FAIL lw_dv: got n=%0d cyc=%0d want n=1 cyc=2", o.dv_n, o.dv_cyc); end
        n_vec++; if (o.md_dv !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_memData: got %h want deadbeef", o.md_dv); end
        n_vec++; if (o.stall_m !== 16'h0003) begin n_err++; $display("FAIL lw_stall: got %h want 0003", o.stall_m); end
        exp_md = 32'hDEADBEEF;
    endtask

    task automatic test_lb_lhu();
        obs_t o;
        do_op(mk(3'b000, 1'b0), 32'h203, 32'h0, 0, 32'h80FFFFFF, o);
        n_vec++; if (o.md_end !== 32'h80000000 || o.dv_n !== 1) begin n_err++; $display("FAIL lb_memData: got %h dv %0d want 80000000 dv 1", o.md_end, o.dv_n); end
        n_vec++; if (o.a !== 32'h200) begin n_err++; $display("FAIL lb_addr: got %h want 00000200", o.a); end
        do_op(mk(3'b101, 1'b0), 32'h202, 32'h0, 2, 32'h1234ABCD, o);
        n_vec++; if (o.md_end !== 32'h12340000 || o.dv_cyc !== 4) begin n_err++; $display("FAIL lhu_memData: got %h cyc %0d want 12340000 cyc 4", o.md_end, o.dv_cyc); end
        exp_md = 32'h12340000;
    endtask

    task automatic test_stores();
        obs_t o;
        do_op(mk(3'b000, 1'b1), 32'h11, 32'h000000A5, 1, 32'hFFFFFFFF, o);
        n_vec++; if (o.we !== 1'b1 || o.st !== 4'b0010) begin n_err++; $display("FAIL sb_we_strb: got we %b strb %b want 1 0010", o.we, o.st); end
        n_vec++; if (o.wd !== 32'hA5A5A5A5 || o.a !== 32'h10) begin n_err++; $display("FAIL sb_data: got wd %h addr %h want a5a5a5a5 00000010", o.wd, o.a); end
        n_vec++; if (o.dv_n !== 0 || o.be_n !== 0 || o.md_end !== exp_md) begin n_err++; $display("FAIL sb_no_pulse: got dv %0d be %0d md %h want 0 0 %h", o.dv_n, o.be_n, o.md_end, exp_md); end
        n_vec++; if (o.req_n !== 2 || o.unstable !== 1'b0 || o.stall_m !== 16'h0007) begin n_err++; $display("FAIL sb_timing: got req %0d unstable %b stall %h want 2 0 0007", o.req_n, o.unstable, o.stall_m); end
        do_op(mk(3'b001, 1'b1), 32'h12, 32'h0000BEEF, 0, 32'h0, o);
        n_vec++; if (o.st !== 4'b1100 || o.wd !== 32'hBEEFBEEF) begin n_err++; $display("FAIL sh_fmt: got strb %b wd %h want 1100 beefbeef", o.st, o.wd); end
        do_op(mk(3'b010, 1'b1), 32'h18, 32'h01234567, 0, 32'h0, o);
        n_vec++; if (o.st !== 4'b1111 || o.wd !== 32'h01234567) begin n_err++; $display("FAIL sw_fmt: got strb %b wd %h want 1111 01234567", o.st, o.wd); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_op(mk(3'b010, 1'b0), 32'h102, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.mis_n !== 1 || o.mis_cyc !== 1) begin n_err++; $display("FAIL lw_mis_pulse: got n=%0d cyc=%0d want 1 1", o.mis_n, o.mis_cyc); end
        n_vec++; if (o.req_n !== 0 || o.stall_m !== 16'h0) begin n_err++; $display("FAIL lw_mis_noreq: got req %0d stall %h want 0 0000", o.req_n, o.stall_m); end
        do_op(mk(3'b001, 1'b1), 32'h13, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.mis_n !== 1 || o.req_n !== 0) begin n_err++; $display("FAIL sh_mis: got mis %0d req %0d want 1 0", o.mis_n, o.req_n); end
        do_op(mk(3'b011, 1'b0), 32'h100, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.mis_n !== 1 || o.req_n !== 0 || o.md_end !== exp_md) begin n_err++; $display("FAIL bad_funct3: got mis %0d req %0d md %h want 1 0 %h", o.mis_n, o.req_n, o.md_end, exp_md); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_op(mk(3'b010, 1'b0), 32'h80, 32'h0, -1, 32'h0, o);
        n_vec++; if (o.req_n !== TO) begin n_err++; $display("FAIL to_req_cycles: got %0d want %0d", o.req_n, TO); end
        n_vec++; if (o.be_n !== 1 || o.be_cyc !== TO + 1) begin n_err++; $display("FAIL to_bus_err: got n=%0d cyc=%0d want 1 %0d", o.be_n, o.be_cyc, TO + 1); end
        n_vec++; if (o.dv_n !== 0 || o.md_end !== exp_md) begin n_err++; $display("FAIL to_no_data: got dv %0d md %h want 0 %h", o.dv_n, o.md_end, exp_md); end
        do_op(mk(3'b010, 1'b0), 32'h84, 32'h0, TO - 1, 32'hCAFEF00D, o);
        n_vec++; if (o.dv_n !== 1 || o.be_n !== 0 || o.md_end !== 32'hCAFEF00D) begin n_err++; $display("FAIL to_ack_wins: got dv %0d be %0d md %h want 1 0 cafef00d", o.dv_n, o.be_n, o.md_end); end
        exp_md = 32'hCAFEF00D;
    endtask

    task automatic test_resp_ignore();
        logic [31:0] r;
        r = $urandom;
        @(negedge clk); valid_in = 1'b1; operation = mk(3'b010, 1'b0); addr = 32'h40; mem_ack = 1'b0;
        @(negedge clk); valid_in = 1'b0; mem_ack = 1'b1; mem_rdata = r;
        @(negedge clk); valid_in = 1'b1; operation = mk(3'b010, 1'b1); addr = 32'h44; store_data = 32'h55; mem_ack = 1'b0;
        #1;
        n_vec++; if (stall !== 1'b0 || data_valid !== 1'b1 || memData !== r) begin n_err++; $display("FAIL resp_cycle: got stall %b dv %b md %h want 0 1 %h", stall, data_valid, memData, r); end
        @(negedge clk); valid_in = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL resp_ignore: got req %b stall %b want 0 0", mem_req, stall); end
        exp_md = r;
    endtask

    task automatic test_reset_busy();
        int bad;
        @(negedge clk); valid_in = 1'b1; operation = mk(3'b010, 1'b0); addr = 32'h300; mem_ack = 1'b0;
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rb_busy: got req %b want 1", mem_req); end
        @(negedge clk); reset = 1'b0;
        #1;
        n_vec++; if ({stall, mem_req, mem_we, data_valid, bus_err, misaligned} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || memData !== 32'h0) begin
            n_err++; $display("FAIL rb_outputs: ctl %b addr %h wd %h st %b md %h want all 0", {stall, mem_req, mem_we, data_valid, bus_err, misaligned}, mem_addr, mem_wdata, mem_wstrb, memData);
        end
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h87654321;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mem_req || data_valid || bus_err || memData !== 32'h0) bad++;
            @(negedge clk); mem_ack = 1'b0;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rb_stray_ack: got %0d bad cycles want 0", bad); end
        exp_md = 32'h0;
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] ad, sd, rd;
        logic [11:0] op;
        logic [2:0]  f3;
        logic [15:0] es;
        int kind, d, sz, off, er;
        bit st, mem, ok, tmo, dv;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            st = (kind >= 5); mem = (kind != 9);
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 1) == 1) ad = ad & 32'hFFFFFFFC;
            d = int'($urandom_range(0, 6)) - 1;
            op = mem ? mk(f3, st) : {5'($urandom), 7'b0110011};
            do_op(op, ad, sd, d, rd, o);
            sz = op_size(f3); off = int'(ad[1:0]);
            ok = mem && sz != 0;
            if (ok) ok = (off % sz) == 0;
            tmo = ok && (d < 0 || d >= TO);
            dv = ok && !tmo && !st;
            er = tmo ? TO : (ok ? d + 1 : 0);
            es = !ok ? 16'h0 : 16'((1 << (er + 1)) - 1);
            if (dv) exp_md = ld_exp(sz, off, rd);
            n_vec++; if (o.stall_m !== es || o.req_n !== er) begin n_err++; $display("FAIL rnd%0d_timing: got stall %h req %0d want %h %0d", i, o.stall_m, o.req_n, es, er); end
            n_vec++; if (o.mis_n !== int'(mem && !ok) || o.be_n !== int'(tmo) || o.dv_n !== int'(dv)) begin
                n_err++; $display("FAIL rnd%0d_pulses: got mis %0d be %0d dv %0d want %0d %0d %0d", i, o.mis_n, o.be_n, o.dv_n, int'(mem && !ok), int'(tmo), int'(dv));
            end
            n_vec++; if (o.md_end !== exp_md) begin n_err++; $display("FAIL rnd%0d_memData: got %h want %h", i, o.md_end, exp_md); end
            if (ok) begin
                n_vec++; if (o.a !== (ad & 32'hFFFFFFFC) || o.we !== st || o.unstable !== 1'b0) begin n_err++; $display("FAIL rnd%0d_bus: got addr %h we %b unstable %b want %h %b 0", i, o.a, o.we, o.unstable, ad & 32'hFFFFFFFC, st); end
                n_vec++; if (o.st !== (st ? st_strb(sz, off) : 4'b0)) begin n_err++; $display("FAIL rnd%0d_strb: got %b want %b", i, o.st, st ? st_strb(sz, off) : 4'b0); end
                if (st) begin
                    n_vec++; if (o.wd !== st_wd(sz, sd)) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", i, o.wd, st_wd(sz, sd)); end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; operation = '0; addr = '0; store_data = '0;
        mem_rdata = '0; mem_ack = 1'b0; exp_md = '0;
        test_reset();
        test_lw();
        test_lb_lhu();
        test_stores();
        test_misaligned();
        test_timeout();
        test_resp_ignore();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
